seq_divider: RTL



---
 rtl/div_pkg.sv | 31 +++
 rtl/div_step.sv | 24 ++
 rtl/seq_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and width-generic helpers for the sequential divider.
// Helpers operate on 32-bit containers and mask to the requested width.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    function automatic logic [31:0] width_mask(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    function automatic logic [31:0] negate(input logic [31:0] v, input int w);
        return (~v + 32'd1) & width_mask(w);
    endfunction

    function automatic logic [31:0] abs_val(input logic [31:0] v, input int w);
        return v[w-1] ? negate(v, w) : (v & width_mask(w));
    endfunction

    function automatic logic [31:0] min_val(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] max_val(input int w);
        return min_val(w) - 32'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   partial,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   partial_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    always_comb begin
        shifted      = {partial, bit_in};
        divisor_ext  = {2'b00, divisor};
        q_bit        = (shifted >= divisor_ext);
        partial_next = q_bit ? (WIDTH+1)'(shifted - divisor_ext)
                             : (WIDTH+1)'(shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with
// valid/ready handshakes and divide-by-zero / signed-overflow status.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t state, next_state;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH:0]   partial, partial_next;
    logic             q_bit;
    logic             neg_q, neg_r;

    logic signed [WIDTH-1:0] dividend_s, divisor_s;
    logic             dvd_neg, dvs_neg;
    logic             divisor_zero, minus_one, dividend_min, special;
    logic             accept, last_step, release_out;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in, special_q;
    logic [WIDTH-1:0] q_mag, r_mag, q_final, r_final;

    // Operand decode for the accept cycle.
    always_comb begin
        dividend_s   = dividend;
        divisor_s    = divisor;
        dvd_neg      = signed_mode && (dividend_s < 0);
        dvs_neg      = signed_mode && (divisor_s < 0);
        dvd_mag_in   = dvd_neg ? WIDTH'(abs_val(32'(dividend), WIDTH)) : dividend;
        dvs_mag_in   = dvs_neg ? WIDTH'(abs_val(32'(divisor), WIDTH)) : divisor;
        divisor_zero = (divisor == '0);
        minus_one    = signed_mode && (divisor == '1);
        dividend_min = (dividend == WIDTH'(min_val(WIDTH)));
        special      = divisor_zero || minus_one;
        if (divisor_zero)
            special_q = '0;
        else if (dividend_min)
            special_q = WIDTH'(max_val(WIDTH));
        else
            special_q = WIDTH'(negate(32'(dividend), WIDTH));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= DIV_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            DIV_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = special ? DIV_DONE : DIV_CALC;
            end
            DIV_CALC: begin
                if (count == LAST_STEP)
                    next_state = DIV_DONE;
            end
            DIV_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    next_state = DIV_IDLE;
            end
            default: next_state = DIV_IDLE;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign last_step   = (state == DIV_CALC) && (count == LAST_STEP);
    assign release_out = (state == DIV_DONE) && out_ready;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial      (partial),
        .bit_in       (work[WIDTH-1]),
        .divisor      (dvsr_mag),
        .partial_next (partial_next),
        .q_bit        (q_bit)
    );

    // The final iteration's result goes straight into the output registers.
    always_comb begin
        q_mag   = {work[WIDTH-2:0], q_bit};
        r_mag   = partial_next[WIDTH-1:0];
        q_final = neg_q ? WIDTH'(negate(32'(q_mag), WIDTH)) : q_mag;
        r_final = neg_r ? WIDTH'(negate(32'(r_mag), WIDTH)) : r_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (accept)
            count <= '0;
        else if (state == DIV_CALC)
            count <= count + 1'b1;
    end

    // Working registers need no reset: each accept reloads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            work     <= dvd_mag_in;
            dvsr_mag <= dvs_mag_in;
            partial  <= '0;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
        end else if (state == DIV_CALC) begin
            work    <= {work[WIDTH-2:0], q_bit};
            partial <= partial_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept && special) begin
            quotient    <= special_q;
            remainder   <= '0;
            div_by_zero <= divisor_zero;
            overflow    <= minus_one && dividend_min;
        end else if (last_step) begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (release_out) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end
    end

endmodule
